// File: rtl/morse_pkg.sv
// Shared Morse definitions: character codes, per-character symbol table, FSM states.
// Pure definitions; the table lookup is combinational with zero latency.
// No flow control here; both the TX engine and the RX side import this package.
package morse_pkg;

  localparam int CH_A     = 0;
  localparam int CH_0     = 26;
  localparam int CH_SPACE = 36;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MARK,
    ST_SPACE,
    ST_GAP
  } state_t;

  // Returns {len[2:0], sym[4:0]}; sym bit 0 is the first symbol, 1 = dash.
  // len == 0 marks a code that has no symbol pattern (word space or invalid).
  function automatic logic [7:0] morse_lut(input logic [5:0] code);
    logic [7:0] r;
    r = 8'h00;
    case (code)
      6'd0:  r = {3'd2, 5'b00010}; // A .-
      6'd1:  r = {3'd4, 5'b00001}; // B -...
      6'd2:  r = {3'd4, 5'b00101}; // C -.-.
      6'd3:  r = {3'd3, 5'b00001}; // D -..
      6'd4:  r = {3'd1, 5'b00000}; // E .
      6'd5:  r = {3'd4, 5'b00100}; // F ..-.
      6'd6:  r = {3'd3, 5'b00011}; // G --.
      6'd7:  r = {3'd4, 5'b00000}; // H ....
      6'd8:  r = {3'd2, 5'b00000}; // I ..
      6'd9:  r = {3'd4, 5'b01110}; // J .---
      6'd10: r = {3'd3, 5'b00101}; // K -.-
      6'd11: r = {3'd4, 5'b00010}; // L .-..
      6'd12: r = {3'd2, 5'b00011}; // M --
      6'd13: r = {3'd2, 5'b00001}; // N -.
      6'd14: r = {3'd3, 5'b00111}; // O ---
      6'd15: r = {3'd4, 5'b00110}; // P .--.
      6'd16: r = {3'd4, 5'b01011}; // Q --.-
      6'd17: r = {3'd3, 5'b00010}; // R .-.
      6'd18: r = {3'd3, 5'b00000}; // S ...
      6'd19: r = {3'd1, 5'b00001}; // T -
      6'd20: r = {3'd3, 5'b00100}; // U ..-
      6'd21: r = {3'd4, 5'b01000}; // V ...-
      6'd22: r = {3'd3, 5'b00110}; // W .--
      6'd23: r = {3'd4, 5'b01001}; // X -..-
      6'd24: r = {3'd4, 5'b01101}; // Y -.--
      6'd25: r = {3'd4, 5'b00011}; // Z --..
      6'd26: r = {3'd5, 5'b11111}; // 0 -----
      6'd27: r = {3'd5, 5'b11110}; // 1 .----
      6'd28: r = {3'd5, 5'b11100}; // 2 ..---
      6'd29: r = {3'd5, 5'b11000}; // 3 ...--
      6'd30: r = {3'd5, 5'b10000}; // 4 ....-
      6'd31: r = {3'd5, 5'b00000}; // 5 .....
      6'd32: r = {3'd5, 5'b00001}; // 6 -....
      6'd33: r = {3'd5, 5'b00011}; // 7 --...
      6'd34: r = {3'd5, 5'b00111}; // 8 ---..
      6'd35: r = {3'd5, 5'b01111}; // 9 ----.
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// Character queue, DEPTH x W, with occupancy count; head is read combinationally.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push_rdy drops when full (pushes then dropped); clear wins over push and pop.
module morse_char_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 6,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          clear,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  output logic          push_rdy,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_fire;
  logic          pop_fire;

  assign push_rdy  = (count != CW'(DEPTH));
  assign push_fire = push_vld && push_rdy && !clear;
  assign pop_fire  = pop && (count != '0) && !clear;
  assign head_dat  = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge iCLK) begin
    if (push_fire) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + AW'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/morse_tx_engine.sv
// Streaming Morse transmitter: queues character codes and keys them onto oLED unit by unit.
// Latency: oLED rises two cycles after an accepted iSend; unit lengths follow iTick strobes.
// Backpressure: oCharReady = FIFO not full; MORSE_TX_WORD_SPACE_EN turns code 36 into a word gap.
module morse_tx_engine
  import morse_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int UNIT_TICKS = 1,
  parameter int CODE_W     = 6
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic                       iTick,
  input  logic [CODE_W-1:0]          iChar,
  input  logic                       iCharValid,
  output logic                       oCharReady,
  input  logic                       iSend,
  input  logic                       iClear,
  output logic                       oLED,
  output logic                       oBusy,
  output logic                       oDone,
  output logic [$clog2(DEPTH+1)-1:0] oCount
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int TCW = $clog2(3 * UNIT_TICKS + 1);

  state_t            state;
  logic [TCW-1:0]    tick_cnt;
  logic [2:0]        unit_left;
  logic [2:0]        sym_idx;
  logic [2:0]        cur_len;
  logic [4:0]        cur_sym;
  logic [CODE_W-1:0] head;
  logic [7:0]        lut;
  logic              pop;
  logic              head_ok;
  logic              push_fire;
  logic              more_after_pop;
  logic              more_now;
  logic              timed;
  logic              unit_end;
  logic              dur_end;

  morse_char_fifo #(.DEPTH(DEPTH), .W(CODE_W)) u_fifo (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .clear    (iClear),
    .push_vld (iCharValid),
    .push_dat (iChar),
    .push_rdy (oCharReady),
    .pop      (pop),
    .head_dat (head),
    .count    (oCount)
  );

  assign pop            = (state == ST_LOAD) && !iClear;
  assign lut            = morse_lut(head[5:0]);
  assign head_ok        = (head < CODE_W'(CH_SPACE));
  assign push_fire      = iCharValid && oCharReady;
  // Occupancy after this cycle's pop/push, used to decide whether to keep draining.
  assign more_after_pop = (oCount > CW'(1)) || push_fire;
  assign more_now       = (oCount != '0) || push_fire;
  assign timed          = (state == ST_MARK) || (state == ST_SPACE) || (state == ST_GAP);
  assign unit_end       = timed && iTick && (tick_cnt == TCW'(UNIT_TICKS - 1));
  assign dur_end        = unit_end && (unit_left == 3'd1);

`ifdef MORSE_TX_WORD_SPACE_EN
  logic head_space;
  assign head_space = (head == CODE_W'(CH_SPACE));
`endif

  // Sequencer: character load, per-symbol mark/space keying and inter-character gaps.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      unit_left <= 3'd0;
      sym_idx   <= 3'd0;
      cur_len   <= 3'd0;
      cur_sym   <= 5'd0;
      oLED      <= 1'b0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
    end else if (iClear) begin
      state <= ST_IDLE;
      oLED  <= 1'b0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
    end else begin
      oDone <= 1'b0;
      // Tick counting inside a unit and unit countdown inside a timed state.
      if (timed && iTick) tick_cnt <= unit_end ? '0 : tick_cnt + TCW'(1);
      if (unit_end && (unit_left != 3'd1)) unit_left <= unit_left - 3'd1;

      case (state)
        ST_IDLE: begin
          if (iSend && (oCount != '0)) begin
            state <= ST_LOAD;
            oBusy <= 1'b1;
          end
        end

        ST_LOAD: begin
          tick_cnt <= '0;
          sym_idx  <= 3'd0;
          if (head_ok) begin
            cur_len   <= lut[7:5];
            cur_sym   <= lut[4:0];
            unit_left <= lut[0] ? 3'd3 : 3'd1;
            oLED      <= 1'b1;
            state     <= ST_MARK;
          end
`ifdef MORSE_TX_WORD_SPACE_EN
          else if (head_space) begin
            unit_left <= 3'd4;
            state     <= ST_GAP;
          end
`endif
          else if (more_after_pop) begin
            state <= ST_LOAD;
          end else begin
            state <= ST_IDLE;
            oBusy <= 1'b0;
            oDone <= 1'b1;
          end
        end

        ST_MARK: begin
          if (dur_end) begin
            oLED <= 1'b0;
            if (sym_idx == cur_len - 3'd1) begin
              unit_left <= 3'd3;
              state     <= ST_GAP;
            end else begin
              unit_left <= 3'd1;
              sym_idx   <= sym_idx + 3'd1;
              state     <= ST_SPACE;
            end
          end
        end

        ST_SPACE: begin
          if (dur_end) begin
            unit_left <= cur_sym[sym_idx] ? 3'd3 : 3'd1;
            oLED      <= 1'b1;
            state     <= ST_MARK;
          end
        end

        ST_GAP: begin
          if (dur_end) begin
            if (more_now) begin
              state <= ST_LOAD;
            end else begin
              state <= ST_IDLE;
              oBusy <= 1'b0;
              oDone <= 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
